// File: rtl/ddr_rw_scheduler.sv
// Burst scheduler sharing one AXI port between the write and read engines, with wrapping ring-buffer addresses.
// Optional: define SCHED_WR_PRIORITY_EN for fixed write priority instead of round-robin arbitration.
module ddr_rw_scheduler #(
  parameter int          AXI_WIDTH = 64,
  parameter logic [7:0]  WR_LEN    = 8'd31,
  parameter logic [7:0]  RD_LEN    = 8'd31,
  parameter logic [29:0] WR_BEG    = 30'd0,
  parameter logic [29:0] WR_END    = 30'h0100_0000,
  parameter logic [29:0] RD_BEG    = 30'd0,
  parameter logic [29:0] RD_END    = 30'h0100_0000,
  parameter int          CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_mem_en,
  input  logic [CNT_W-1:0] wr_fifo_cnt,
  input  logic [CNT_W-1:0] rd_fifo_free,
  input  logic             wr_ready,
  input  logic             wr_done,
  input  logic             rd_ready,
  input  logic             rd_done,
  output logic             wr_start,
  output logic [29:0]      wr_addr,
  output logic [7:0]       wr_len,
  output logic             rd_start,
  output logic [29:0]      rd_addr,
  output logic [7:0]       rd_len,
  output logic             busy,
  output logic             wr_wrap
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4
  } state_t;

  localparam int WR_STEP_I = (int'(WR_LEN) + 1) * (AXI_WIDTH / 8);
  localparam int RD_STEP_I = (int'(RD_LEN) + 1) * (AXI_WIDTH / 8);
  localparam logic [30:0] WR_STEP = 31'(WR_STEP_I);
  localparam logic [30:0] RD_STEP = 31'(RD_STEP_I);
  localparam logic [CNT_W:0] WR_BEATS = (CNT_W+1)'(int'(WR_LEN) + 1);
  localparam logic [CNT_W:0] RD_BEATS = (CNT_W+1)'(int'(RD_LEN) + 1);

  state_t      state_q;
  logic        wr_start_q, rd_start_q, busy_q, wr_wrap_q;
  logic [29:0] wr_addr_q, rd_addr_q;
  logic [29:0] wr_addr_d, rd_addr_d;
  logic [30:0] wr_sum, rd_sum;
  logic        wr_wrap_d;
  logic        wr_req, rd_req, tie_wr;

  assign wr_req = {1'b0, wr_fifo_cnt} >= WR_BEATS;
  assign rd_req = rd_mem_en && ({1'b0, rd_fifo_free} >= RD_BEATS);

  // 31-bit sums so a region ending near the top of the 30-bit space cannot overflow
  assign wr_sum    = {1'b0, wr_addr_q} + WR_STEP;
  assign rd_sum    = {1'b0, rd_addr_q} + RD_STEP;
  assign wr_wrap_d = wr_sum >= {1'b0, WR_END};
  assign wr_addr_d = wr_wrap_d ? WR_BEG : wr_sum[29:0];
  assign rd_addr_d = (rd_sum >= {1'b0, RD_END}) ? RD_BEG : rd_sum[29:0];

`ifdef SCHED_WR_PRIORITY_EN
  assign tie_wr = 1'b1;
`else
  logic last_rd_q;  // 1 when the most recent grant went to the read side
  assign tie_wr = last_rd_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_wrap_q  <= 1'b0;
      wr_addr_q  <= WR_BEG;
      rd_addr_q  <= RD_BEG;
`ifndef SCHED_WR_PRIORITY_EN
      last_rd_q  <= 1'b1;
`endif
    end else begin
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      wr_wrap_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_req && (!rd_req || tie_wr)) begin
            state_q <= WR_ISSUE;
            busy_q  <= 1'b1;
          end else if (rd_req) begin
            state_q <= RD_ISSUE;
            busy_q  <= 1'b1;
          end
        end
        WR_ISSUE: begin
          if (wr_ready) begin
            wr_start_q <= 1'b1;
            state_q    <= WR_WAIT;
`ifndef SCHED_WR_PRIORITY_EN
            last_rd_q  <= 1'b0;
`endif
          end
        end
        WR_WAIT: begin
          if (wr_done) begin
            wr_addr_q <= wr_addr_d;
            wr_wrap_q <= wr_wrap_d;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
        end
        RD_ISSUE: begin
          if (rd_ready) begin
            rd_start_q <= 1'b1;
            state_q    <= RD_WAIT;
`ifndef SCHED_WR_PRIORITY_EN
            last_rd_q  <= 1'b1;
`endif
          end
        end
        RD_WAIT: begin
          if (rd_done) begin
            rd_addr_q <= rd_addr_d;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_start = wr_start_q;
  assign rd_start = rd_start_q;
  assign wr_addr  = wr_addr_q;
  assign rd_addr  = rd_addr_q;
  assign wr_len   = WR_LEN;
  assign rd_len   = RD_LEN;
  assign busy     = busy_q;
  assign wr_wrap  = wr_wrap_q;

endmodule

// File: tb/tb_ddr_rw_scheduler.sv
// Directed bench for ddr_rw_scheduler: 8-beat bursts of 64-bit words, 256-byte write ring at 0, read ring at 256.
module tb_ddr_rw_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_mem_en;
  logic [9:0]  wr_fifo_cnt, rd_fifo_free;
  logic        wr_ready, wr_done, rd_ready, rd_done;
  logic        wr_start, rd_start, busy, wr_wrap;
  logic [29:0] wr_addr, rd_addr;
  logic [7:0]  wr_len, rd_len;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ddr_rw_scheduler #(
    .AXI_WIDTH(64), .WR_LEN(8'd7), .RD_LEN(8'd7),
    .WR_BEG(30'd0), .WR_END(30'd256), .RD_BEG(30'd256), .RD_END(30'd512), .CNT_W(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_mem_en(rd_mem_en),
    .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_free(rd_fifo_free),
    .wr_ready(wr_ready), .wr_done(wr_done), .rd_ready(rd_ready), .rd_done(rd_done),
    .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
    .busy(busy), .wr_wrap(wr_wrap)
  );

  // Waits up to 20 falling edges for the chosen start pulse; waited = -1 on timeout.
  task automatic wait_start(input bit is_wr, output int waited);
    waited = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((is_wr && wr_start) || (!is_wr && rd_start)) begin
        waited = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_mem_en = 1'b0; wr_fifo_cnt = '0; rd_fifo_free = '0;
    wr_ready = 1'b0; wr_done = 1'b0; rd_ready = 1'b0; rd_done = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({wr_start, rd_start, busy, wr_wrap} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags got %b expected 0000", {wr_start, rd_start, busy, wr_wrap});
    end
    vectors++;
    if (wr_addr !== 30'd0 || rd_addr !== 30'd256) begin
      miscompares++; $display("FAIL reset_addr got wr=%0d rd=%0d expected wr=0 rd=256", wr_addr, rd_addr);
    end
    vectors++;
    if (wr_len !== 8'd7 || rd_len !== 8'd7) begin
      miscompares++; $display("FAIL lens got wr=%0d rd=%0d expected 7 7", wr_len, rd_len);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    wr_fifo_cnt = 10'd8; wr_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || wr_start !== 1'b0) begin
      miscompares++; $display("FAIL sw_issue got busy=%b wr_start=%b expected 1 0", busy, wr_start);
    end
    @(negedge clk);
    vectors++;
    if (wr_start !== 1'b1 || wr_addr !== 30'd0 || rd_start !== 1'b0) begin
      miscompares++; $display("FAIL sw_start got wr_start=%b wr_addr=%0d rd_start=%b expected 1 0 0", wr_start, wr_addr, rd_start);
    end
    wr_fifo_cnt = 10'd0;
    @(negedge clk);
    vectors++;
    if (wr_start !== 1'b0 || wr_addr !== 30'd0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL sw_wait got wr_start=%b wr_addr=%0d busy=%b expected 0 0 1", wr_start, wr_addr, busy);
    end
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    vectors++;
    if (wr_addr !== 30'd64 || busy !== 1'b0 || wr_wrap !== 1'b0) begin
      miscompares++; $display("FAIL sw_done got wr_addr=%0d busy=%b wr_wrap=%b expected 64 0 0", wr_addr, busy, wr_wrap);
    end
  endtask

  task automatic test_threshold();
    int starts = 0, busy_cnt = 0;
    wr_fifo_cnt = 10'd7; wr_ready = 1'b1; rd_ready = 1'b1;
    rd_mem_en = 1'b0; rd_fifo_free = 10'd1023;
    for (int i = 0; i < 100; i++) begin
      wr_done = (i == 50); rd_done = (i == 60);
      @(negedge clk);
      if (wr_start || rd_start) starts++;
      if (busy) busy_cnt++;
    end
    wr_done = 1'b0; rd_done = 1'b0;
    vectors++;
    if (starts !== 0 || busy_cnt !== 0) begin
      miscompares++; $display("FAIL below_threshold got starts=%0d busy_cycles=%0d expected 0 0", starts, busy_cnt);
    end
    vectors++;
    if (wr_addr !== 30'd64 || rd_addr !== 30'd256) begin
      miscompares++; $display("FAIL idle_done_ignored got wr=%0d rd=%0d expected 64 256", wr_addr, rd_addr);
    end
    wr_fifo_cnt = 10'd0;
  endtask

  task automatic test_wr_ready_stall();
    int starts = 0;
    wr_fifo_cnt = 10'd8; wr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wr_start) starts++;
    end
    vectors++;
    if (starts !== 0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL stall_hold got starts=%0d busy=%b expected 0 1", starts, busy);
    end
    wr_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (wr_start !== 1'b1 || wr_addr !== 30'd64) begin
      miscompares++; $display("FAIL stall_start got wr_start=%b wr_addr=%0d expected 1 64", wr_start, wr_addr);
    end
    wr_fifo_cnt = 10'd0; wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    vectors++;
    if (wr_start !== 1'b0 || wr_addr !== 30'd128) begin
      miscompares++; $display("FAIL stall_done got wr_start=%b wr_addr=%0d expected 0 128", wr_start, wr_addr);
    end
  endtask

  task automatic test_wrap();
    int w;
    logic [29:0] exp_addr [2] = '{30'd192, 30'd0};
    logic        exp_wrap [2] = '{1'b0, 1'b1};
    for (int b = 0; b < 2; b++) begin
      wr_fifo_cnt = 10'd8; wr_ready = 1'b1;
      wait_start(1'b1, w);
      vectors++;
      if (w < 0) begin
        miscompares++; $display("FAIL wrap_start%0d got timeout expected wr_start", b);
      end
      wr_fifo_cnt = 10'd0; wr_done = 1'b1;
      @(negedge clk);
      wr_done = 1'b0;
      vectors++;
      if (wr_addr !== exp_addr[b] || wr_wrap !== exp_wrap[b]) begin
        miscompares++; $display("FAIL wrap_burst%0d got addr=%0d wrap=%b expected %0d %b", b, wr_addr, wr_wrap, exp_addr[b], exp_wrap[b]);
      end
    end
    @(negedge clk);
    vectors++;
    if (wr_wrap !== 1'b0) begin
      miscompares++; $display("FAIL wrap_pulse_len got wr_wrap=%b expected 0", wr_wrap);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, wn = 0, rn = 0, both = 0;
    bit exp_wr;
    rst_n = 1'b0;
    @(negedge clk);
    wr_fifo_cnt = 10'd8; rd_mem_en = 1'b1; rd_fifo_free = 10'd8;
    wr_ready = 1'b1; rd_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 46; i++) begin
      if (i == 40) begin
        wr_fifo_cnt = 10'd0; rd_mem_en = 1'b0;
      end
      @(negedge clk);
      wr_done = 1'b0; rd_done = 1'b0;
      if (wr_start && rd_start) both++;
      if (wr_start || rd_start) begin
`ifdef SCHED_WR_PRIORITY_EN
        exp_wr = 1'b1;
`else
        exp_wr = (n % 2) == 0;
`endif
        if (n < 8) begin
          vectors++;
          if (wr_start !== exp_wr) begin
            miscompares++; $display("FAIL rr_order%0d got wr_start=%b expected %b", n, wr_start, exp_wr);
          end
        end
        if (wr_start) begin
          vectors++;
          if (wr_addr !== 30'(64 * (wn % 4))) begin
            miscompares++; $display("FAIL rr_wr_addr%0d got %0d expected %0d", wn, wr_addr, 64 * (wn % 4));
          end
          wn++; wr_done = 1'b1;
        end else begin
          vectors++;
          if (rd_addr !== 30'(256 + 64 * (rn % 4))) begin
            miscompares++; $display("FAIL rr_rd_addr%0d got %0d expected %0d", rn, rd_addr, 256 + 64 * (rn % 4));
          end
          rn++; rd_done = 1'b1;
        end
        n++;
      end
    end
    wr_done = 1'b0; rd_done = 1'b0;
    vectors++;
    if (both !== 0 || n < 8 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rr_summary got simultaneous=%0d starts=%0d busy=%b expected 0 >=8 0", both, n, busy);
    end
  endtask

  task automatic test_reset_mid_read();
    int w, starts = 0;
    rd_mem_en = 1'b1; rd_fifo_free = 10'd8; rd_ready = 1'b1; wr_fifo_cnt = 10'd0;
    wait_start(1'b0, w);
    vectors++;
    if (w < 0) begin
      miscompares++; $display("FAIL mid_rd_start got timeout expected rd_start");
    end
    rd_mem_en = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL rd_no_abort got busy=%b expected 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (rd_addr !== 30'd256 || busy !== 1'b0 || rd_start !== 1'b0 || wr_addr !== 30'd0) begin
      miscompares++; $display("FAIL async_reset got rd_addr=%0d busy=%b rd_start=%b wr_addr=%0d expected 256 0 0 0", rd_addr, busy, rd_start, wr_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_start || busy) starts++;
    end
    vectors++;
    if (starts !== 0) begin
      miscompares++; $display("FAIL post_reset_quiet got active_cycles=%0d expected 0", starts);
    end
    rd_mem_en = 1'b1;
    wait_start(1'b0, w);
    vectors++;
    if (w !== 2 || rd_addr !== 30'd256) begin
      miscompares++; $display("FAIL rd_restart got latency=%0d rd_addr=%0d expected 2 256", w, rd_addr);
    end
    rd_mem_en = 1'b0; rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    vectors++;
    if (rd_addr !== 30'd320 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rd_done_addr got rd_addr=%0d busy=%b expected 320 0", rd_addr, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_threshold();
    test_wr_ready_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
